register_serializer: RTL and testbench

REGISTER_SERIALIZER -- requirements
Module: register_serializer

---
 rtl/register_serializer_if.sv | 25 ++
 rtl/register_serializer.sv | 120 ++++++++++++
 tb/tb_register_serializer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/register_serializer_if.sv
// Parallel-in / serial-out handshake bundle for register_serializer.
// master = word source and serial sink side, slave = the serializer.
interface register_serializer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output data_in, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  data_in, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/register_serializer.sv
// Loads a WIDTH-bit word and shifts it out one bit per ser_valid/ser_ready handshake.
// Define REGISTER_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module register_serializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  register_serializer_if.slave bus
);
  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef REGISTER_SERIALIZER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             w_in_ready;
  logic             w_ser_valid;
  logic             w_ser_out;
  logic             w_ser_first;
  logic             w_ser_last;
  logic             w_accept;
  logic             w_shift_adv;
`ifdef REGISTER_SERIALIZER_PARITY_EN
  logic             r_parity;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_ser_valid  = 1'b0;
    w_ser_out    = 1'b0;
    w_ser_first  = 1'b0;
    w_ser_last   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_ser_valid = 1'b1;
        w_ser_out   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        w_ser_first = (r_cnt == '0);
`ifdef REGISTER_SERIALIZER_PARITY_EN
        w_ser_last  = 1'b0;
        if (bus.ser_ready && (r_cnt == LAST_IDX)) begin
          w_state_next = PARITY;
        end
`else
        w_ser_last  = (r_cnt == LAST_IDX);
        if (bus.ser_ready && (r_cnt == LAST_IDX)) begin
          w_state_next = IDLE;
        end
`endif
      end
`ifdef REGISTER_SERIALIZER_PARITY_EN
      PARITY: begin
        w_ser_valid = 1'b1;
        w_ser_out   = r_parity;
        w_ser_last  = 1'b1;
        if (bus.ser_ready) begin
          w_state_next = IDLE;
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_accept    = bus.in_valid && w_in_ready;
  // Only data bits move the shift register and counter; the parity bit does not.
  assign w_shift_adv = (r_state == SHIFT) && bus.ser_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
`ifdef REGISTER_SERIALIZER_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shift  <= bus.data_in;
      r_cnt    <= '0;
`ifdef REGISTER_SERIALIZER_PARITY_EN
      r_parity <= ^bus.data_in;
`endif
    end else if (w_shift_adv) begin
      r_shift  <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = !w_in_ready;
  assign bus.ser_valid = w_ser_valid;
  assign bus.ser_out   = w_ser_out;
  assign bus.ser_first = w_ser_first;
  assign bus.ser_last  = w_ser_last;
endmodule

// File: tb/tb_register_serializer.sv
// Directed bench: MSB-first and LSB-first 8-bit serializers plus a 1-bit one, all checked
// bit by bit against hand-computed sequences (parity frames when the parity macro is set).
module tb_register_serializer;
`ifdef REGISTER_SERIALIZER_PARITY_EN
  localparam int NB  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 8;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       in_valid = 1'b0;
  logic       ser_ready = 1'b1;
  logic       c_data = 1'b0;
  logic       c_valid = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  register_serializer_if #(.WIDTH(8)) if_a ();
  register_serializer_if #(.WIDTH(8)) if_b ();
  register_serializer_if #(.WIDTH(1)) if_c ();

  assign if_a.data_in   = data;
  assign if_a.in_valid  = in_valid;
  assign if_a.ser_ready = ser_ready;
  assign if_b.data_in   = data;
  assign if_b.in_valid  = in_valid;
  assign if_b.ser_ready = ser_ready;
  assign if_c.data_in   = c_data;
  assign if_c.in_valid  = c_valid;
  assign if_c.ser_ready = ser_ready;

  register_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  register_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  register_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // seq_m / seq_l: transmitted bit order for MSB-first / LSB-first, first bit in [7].
  typedef struct {
    logic [7:0] word;
    logic [7:0] seq_m;
    logic [7:0] seq_l;
    logic       par;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_a_ready"}, 32'(if_a.in_ready),  32'd1);
    chk({tag, "_a_busy"},  32'(if_a.busy),      32'd0);
    chk({tag, "_a_valid"}, 32'(if_a.ser_valid), 32'd0);
    chk({tag, "_a_out"},   32'(if_a.ser_out),   32'd0);
    chk({tag, "_a_fl"},    32'({if_a.ser_first, if_a.ser_last}), 32'd0);
    chk({tag, "_b_ready"}, 32'(if_b.in_ready),  32'd1);
    chk({tag, "_b_busy"},  32'(if_b.busy),      32'd0);
    chk({tag, "_b_valid"}, 32'(if_b.ser_valid), 32'd0);
    chk({tag, "_b_out"},   32'(if_b.ser_out),   32'd0);
    chk({tag, "_b_fl"},    32'({if_b.ser_first, if_b.ser_last}), 32'd0);
  endtask

  task automatic chk_bit(input string tag, input int idx, input logic [7:0] sm,
                         input logic [7:0] sl, input logic par);
    logic em, el;
    string n;
    if (idx < 8) begin
      em = sm[7-idx];
      el = sl[7-idx];
    end else begin
      em = par;
      el = par;
    end
    n = $sformatf("%s_bit%0d", tag, idx);
    chk({n, "_a_valid"}, 32'(if_a.ser_valid), 32'd1);
    chk({n, "_a_out"},   32'(if_a.ser_out),   32'(em));
    chk({n, "_a_first"}, 32'(if_a.ser_first), 32'(idx == 0));
    chk({n, "_a_last"},  32'(if_a.ser_last),  32'(idx == NB - 1));
    chk({n, "_a_busy"},  32'({if_a.busy, if_a.in_ready}), 32'd2);
    chk({n, "_b_valid"}, 32'(if_b.ser_valid), 32'd1);
    chk({n, "_b_out"},   32'(if_b.ser_out),   32'(el));
    chk({n, "_b_first"}, 32'(if_b.ser_first), 32'(idx == 0));
    chk({n, "_b_last"},  32'(if_b.ser_last),  32'(idx == NB - 1));
  endtask

  // Accept one word, walk its bits (optionally stalling), then check the idle gap cycle.
  task automatic run_frame(input string tag, input logic [7:0] word, input logic [7:0] sm,
                           input logic [7:0] sl, input logic par, input bit hold_valid,
                           input logic [7:0] next_data, input int stall_at, input int stall_n);
    data = word;
    in_valid = 1'b1;
    step();
    if (!hold_valid) in_valid = 1'b0;
    data = next_data;
    for (int i = 0; i < NB; i++) begin
      chk_bit(tag, i, sm, sl, par);
      if (i == stall_at) begin
        ser_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          step();
          chk_bit({tag, "_stall"}, i, sm, sl, par);
        end
        ser_ready = 1'b1;
      end
      step();
    end
    chk_idle({tag, "_gap"});
    $display("frame %s word=%02h bits=%0d total=%0d bad=%0d", tag, word, NB, total, bad);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h01, 8'h01, 8'h80, 1'b1};
    vecs[2] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    vecs[3] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h01, 1'b1};
    vecs[5] = '{8'h0F, 8'h0F, 8'hF0, 1'b0};
    vecs[6] = '{8'hD2, 8'hD2, 8'h4B, 1'b0};

    #2;
    chk_idle("reset");
    chk("reset_c_ready", 32'({if_c.in_ready, if_c.busy, if_c.ser_valid}), 32'd4);
    #10;
    rst = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].word, vecs[v].seq_m, vecs[v].seq_l,
                vecs[v].par, 1'b0, ~vecs[v].word, -1, 0);
    end

    // Downstream stall of three cycles on bit 2.
    run_frame("stall", 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 8'h00, 2, 3);

    // Reset in the middle of bit 4 of 0xFF; outputs must drop before any clock edge.
    data = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit("rstframe", i, 8'hFF, 8'hFF, 1'b0);
      step();
    end
    chk_bit("rstframe", 4, 8'hFF, 8'hFF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    #2;
    rst = 1'b0;
    #1;
    chk_idle("post_rst");
    $display("frame rstframe word=ff aborted at bit 4 total=%0d bad=%0d", total, bad);
    run_frame("after_rst", 8'h0F, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, -1, 0);

    // in_valid held: 0x22 must wait for the gap after 0x11.
    run_frame("b2b_1", 8'h11, 8'h11, 8'h88, 1'b0, 1'b1, 8'h22, -1, 0);
    run_frame("b2b_2", 8'h22, 8'h22, 8'h44, 1'b0, 1'b0, 8'h00, -1, 0);

    // WIDTH=1 serializer.
    c_data = 1'b1;
    c_valid = 1'b1;
    step();
    c_valid = 1'b0;
    c_data = 1'b0;
    chk("w1_valid", 32'(if_c.ser_valid), 32'd1);
    chk("w1_out",   32'(if_c.ser_out),   32'd1);
    chk("w1_first", 32'(if_c.ser_first), 32'd1);
    chk("w1_last",  32'(if_c.ser_last),  32'(!PAR));
    chk("w1_busy",  32'(if_c.busy),      32'd1);
    step();
`ifdef REGISTER_SERIALIZER_PARITY_EN
    chk("w1_par_valid", 32'(if_c.ser_valid), 32'd1);
    chk("w1_par_out",   32'(if_c.ser_out),   32'd1);
    chk("w1_par_fl",    32'({if_c.ser_first, if_c.ser_last}), 32'd1);
    step();
`endif
    chk("w1_gap", 32'({if_c.in_ready, if_c.busy, if_c.ser_valid}), 32'd4);
    $display("frame w1 word=1 total=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
